// File: rtl/alu_issue_stage.sv
// Decode/issue register ahead of the ALU for RV32I OP, OP-IMM, LUI and AUIPC.
// Optional operand forwarding is enabled by defining FORWARD_EN.
module alu_issue_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [31:0]     pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
`ifdef FORWARD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  output logic [XLEN-1:0] opdA,
  output logic [XLEN-1:0] opdB,
  output logic [3:0]      op_sel,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [3:0] SEL_ADD    = 4'b0000;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // RESET_PC only records where the pc stream starts; it carries no logic.
  if (RESET_PC[1:0] != 2'b00) begin : g_pc_origin_unaligned
  end

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [3:0]      dec_sel;
  logic            dec_legal;
  logic            dec_write;

  logic [XLEN-1:0] opd_a_reg;
  logic [XLEN-1:0] opd_b_reg;
  logic [3:0]      op_sel_reg;
  logic [4:0]      rd_reg;
  logic            reg_write_reg;
  logic            illegal_reg;
  logic            valid_reg;
  logic            load;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_u    = {instr[31:12], 12'b0};

`ifdef FORWARD_EN
  // Forwarded result wins over stale register-file data; x0 is never forwarded.
  always_comb begin
    src_a = rs1_data;
    src_b = rs2_data;
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs1_addr)) src_a = fwd_data;
    if (fwd_valid && (fwd_rd != 5'd0) && (fwd_rd == rs2_addr)) src_b = fwd_data;
  end
`else
  assign src_a = rs1_data;
  assign src_b = rs2_data;
`endif

  always_comb begin
    dec_a     = '0;
    dec_b     = '0;
    dec_sel   = SEL_ADD;
    dec_legal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_a     = src_a;
        dec_b     = src_b;
        dec_sel   = {instr[30], funct3};
        dec_legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec_a   = src_a;
        dec_b   = imm_i;
        // Only the right shift uses bit 30 to pick SRA; ADDI never becomes SUB.
        dec_sel = (funct3 == 3'b101) ? {instr[30], 3'b101} : {1'b0, funct3};
        if (funct3 == 3'b001)
          dec_legal = (funct7 == F7_ZERO);
        else if (funct3 == 3'b101)
          dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
      end
      OPC_LUI: begin
        dec_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = pc;
        dec_b = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_a   = '0;
      dec_b   = '0;
      dec_sel = SEL_ADD;
    end
  end

  assign dec_write = dec_legal && (instr[11:7] != 5'd0);
  assign in_ready  = !flush && (!valid_reg || out_ready);
  assign load      = in_valid && in_ready;

  // Priority: reset, then flush, then load, then plain consumption.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg     <= 1'b0;
      opd_a_reg     <= '0;
      opd_b_reg     <= '0;
      op_sel_reg    <= SEL_ADD;
      rd_reg        <= 5'd0;
      reg_write_reg <= 1'b0;
      illegal_reg   <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg     <= 1'b1;
      opd_a_reg     <= dec_a;
      opd_b_reg     <= dec_b;
      op_sel_reg    <= dec_sel;
      rd_reg        <= instr[11:7];
      reg_write_reg <= dec_write;
      illegal_reg   <= !dec_legal;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign opdA      = opd_a_reg;
  assign opdB      = opd_b_reg;
  assign op_sel    = op_sel_reg;
  assign rd        = rd_reg;
  assign reg_write = reg_write_reg;
  assign illegal   = illegal_reg;
  assign out_valid = valid_reg;

endmodule
